// File: rtl/vga_text_renderer.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_renderer
// Description : Character-cell text renderer. Maps pixel coordinates to screen
//               buffer and tile ROM reads, adds a blinking block cursor and
//               emits registered RGB444 with sync/blank delayed 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_renderer #(
    parameter int          H_TILES       = 80,
    parameter int          V_TILES       = 30,
    parameter int          WORDS_PER_ROW = 20,
    parameter int          ADDR_WIDTH    = 10,
    parameter int          DATA_WIDTH    = 28,
    parameter int          SINGLE_DATA   = 7,
    parameter logic [11:0] FG_COLOR      = 12'hFFF,
    parameter logic [11:0] BG_COLOR      = 12'h000,
    parameter logic        SYNC_ACTIVE   = 1'b0,
    parameter int          BLINK_FRAMES  = 30
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [9:0]             hpos_i,
    input  logic [9:0]             vpos_i,
    input  logic                   video_on_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    output logic [ADDR_WIDTH-1:0]  buf_addr_o,
    input  logic [DATA_WIDTH-1:0]  buf_data_i,
    output logic [10:0]            tile_addr_o,
    input  logic [7:0]             tile_data_i,
    input  logic                   cursor_en_i,
    input  logic [11:0]            cursor_pos_i,
    output logic [11:0]            rgb_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   video_on_o
);

    localparam int                 C_CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(BLINK_FRAMES - 1);
    localparam logic               C_SYNC_OFF = ~SYNC_ACTIVE;

    // Stage 0: tile coordinates and buffer address
    logic [6:0]  w_htile;
    logic [4:0]  w_vtile;
    logic [11:0] w_tile_idx;
    logic        w_unused;

    assign w_htile    = hpos_i[9:3];
    assign w_vtile    = vpos_i[8:4];
    assign w_unused   = vpos_i[9];
    assign w_tile_idx = 12'(w_vtile) * 12'(H_TILES) + 12'(w_htile);
    assign buf_addr_o = video_on_i
                      ? (ADDR_WIDTH'(w_vtile) * ADDR_WIDTH'(WORDS_PER_ROW) + ADDR_WIDTH'(w_htile[6:2]))
                      : '0;

    logic [1:0]  r1_sel;
    logic [3:0]  r1_row;
    logic [2:0]  r1_col;
    logic [11:0] r1_idx;
    logic        r1_von;
    logic        r1_hs;
    logic        r1_vs;

    logic [2:0]  r2_col;
    logic        r2_hit;
    logic        r2_von;
    logic        r2_hs;
    logic        r2_vs;

    logic               r_vs_prev;
    logic [C_CNT_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Stage 1: unpack character, sel 0 sits in the low bits of the word
    logic [SINGLE_DATA-1:0] w_char;
    logic                   w_hit;

    assign w_char      = buf_data_i[r1_sel*SINGLE_DATA +: SINGLE_DATA];
    assign tile_addr_o = {w_char, r1_row};
    assign w_hit       = cursor_en_i && r1_von && (r1_idx == cursor_pos_i);

    // Stage 2: pixel select, bit 7 is the leftmost pixel of the tile row
    logic w_bit;
    logic w_pix;
    logic w_vs_edge;

    assign w_bit     = tile_data_i[3'd7 - r2_col];
    assign w_pix     = w_bit ^ (r2_hit & r_phase);
    assign w_vs_edge = (vsync_i == SYNC_ACTIVE) && (r_vs_prev != SYNC_ACTIVE);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r1_sel      <= '0;
            r1_row      <= '0;
            r1_col      <= '0;
            r1_idx      <= '0;
            r1_von      <= 1'b0;
            r1_hs       <= C_SYNC_OFF;
            r1_vs       <= C_SYNC_OFF;
            r2_col      <= '0;
            r2_hit      <= 1'b0;
            r2_von      <= 1'b0;
            r2_hs       <= C_SYNC_OFF;
            r2_vs       <= C_SYNC_OFF;
            rgb_o       <= '0;
            hsync_o     <= C_SYNC_OFF;
            vsync_o     <= C_SYNC_OFF;
            video_on_o  <= 1'b0;
            r_vs_prev   <= C_SYNC_OFF;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r1_sel      <= w_htile[1:0];
            r1_row      <= vpos_i[3:0];
            r1_col      <= hpos_i[2:0];
            r1_idx      <= w_tile_idx;
            r1_von      <= video_on_i;
            r1_hs       <= hsync_i;
            r1_vs       <= vsync_i;
            r2_col      <= r1_col;
            r2_hit      <= w_hit;
            r2_von      <= r1_von;
            r2_hs       <= r1_hs;
            r2_vs       <= r1_vs;
            rgb_o       <= r2_von ? (w_pix ? FG_COLOR : BG_COLOR) : 12'h000;
            hsync_o     <= r2_hs;
            vsync_o     <= r2_vs;
            video_on_o  <= r2_von;
            r_vs_prev   <= vsync_i;
            // Count frames on entry into vsync; toggle the cursor each half-period
            if (w_vs_edge) begin
                if (r_blink_cnt == C_CNT_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Downstream consumer of the screen buffer: converts the sync generator's pixel coordinates into buffer read addresses.
- Unpacks the 4×7-bit character word returned by the buffer, addresses the tile (font bitmap) ROM, and selects the pixel bit.
- Emits registered 12-bit RGB, with sync and blanking delayed to match.
- Adds a blinking block cursor driven by a frame counter.

Parameters:
- H_TILES, 80, characters per row
- V_TILES, 30, character rows
- WORDS_PER_ROW, 20, buffer words per character row (H_TILES/4)
- ADDR_WIDTH, 10, buffer address width
- DATA_WIDTH, 28, buffer word width (4×7)
- SINGLE_DATA, 7, character code width
- FG_COLOR, 12'hFFF, foreground RGB444
- BG_COLOR, 12'h000, background RGB444
- SYNC_ACTIVE, 1'b0, active level of hsync/vsync
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk_i  in  1  25 MHz pixel clock
- rstn_i  in  1  synchronous active-low reset
- hpos_i  in  10  current pixel column, 0..799
- vpos_i  in  10  current pixel line, 0..524
- video_on_i  in  1  active-area flag
- hsync_i  in  1  horizontal sync from generator
- vsync_i  in  1  vertical sync from generator
- buf_addr_o  out  ADDR_WIDTH  read address to screen buffer (vr_addr_i)
- buf_data_i  in  DATA_WIDTH  buffer word, valid 1 cycle after address
- tile_addr_o  out  11  {char[6:0], row[3:0]} to tile ROM
- tile_data_i  in  8  tile row bitmap, valid 1 cycle after address; bit 7 is the leftmost pixel
- cursor_en_i  in  1  cursor enable
- cursor_pos_i  in  12  cursor tile index, 0..2399 (vtile*80+htile)
- rgb_o  out  12  pixel colour, registered
- hsync_o  out  1  hsync delayed 3 cycles
- vsync_o  out  1  vsync delayed 3 cycles
- video_on_o  out  1  video_on delayed 3 cycles

Behaviour:
- Reset (rstn_i=0 at posedge):
  - rgb_o=0, video_on_o=0, hsync_o=vsync_o=~SYNC_ACTIVE.
  - All pipeline registers cleared.
  - Blink counter=0, blink phase=0.
- Stage 0 (cycle t), combinational from inputs:
  - htile=hpos_i[9:3], vtile=vpos_i[8:4].
  - buf_addr_o = vtile*WORDS_PER_ROW + htile[6:2].
  - When video_on_i=0, buf_addr_o=0 so the address never exceeds 599.
  - Register sel=htile[1:0], row=vpos_i[3:0], col=hpos_i[2:0], tile index=vtile*80+htile, video_on, hsync, vsync.
- Stage 1 (cycle t+1):
  - char = buf_data_i[sel*7 +: 7]; sel 0 is the leftmost tile of the word.
  - tile_addr_o = {char,row}, combinational from the stage-1 registers.
  - Register col, cursor-hit flag, video_on, hsync, vsync.
  - Cursor hit = cursor_en_i && tile index == cursor_pos_i.
- Stage 2 (cycle t+2):
  - bit = tile_data_i[7-col].
  - pix = bit XOR (hit & blink phase).
- Output register (valid cycle t+3):
  - rgb_o = video_on ? (pix ? FG_COLOR : BG_COLOR) : 0.
  - hsync_o, vsync_o, video_on_o carry their stage values.
- Latency: exactly 3 cycles from input coordinates/syncs to all outputs. No stalls; one pixel accepted per cycle.
- Blink:
  - Detect the vsync_i transition into SYNC_ACTIVE, using a registered previous value.
  - On each detected edge the counter increments. When the counter reaches BLINK_FRAMES-1, it clears and the blink phase toggles.
- Boundaries:
  - Last tile (hpos 632..639, vpos 464..479): buf_addr_o=599, sel=3.
  - Cursor values ≥2400 never hit.
  - cursor_en_i low forces no inversion; counter keeps running.
- Reset mid-frame: pipeline flushed; the first meaningful output appears 3 cycles after rstn_i rises; blink state restarts from 0.
- Simultaneous vsync edge and reset: reset wins.

Test Plan:
- Reset: hold rstn_i=0 with video_on_i=1 → rgb_o=12'h000, hsync_o=vsync_o=1, video_on_o=0 every cycle.
- Address/unpack: hpos=40, vpos=35, video_on=1 → same cycle buf_addr_o=41. Next cycle, given buf_data_i={7'h00,7'h00,7'h41,7'h00}, tile_addr_o=11'h413. Then tile_data_i=8'h80 → rgb_o=12'hFFF at t+3. Repeating with hpos=45 (col 5) → rgb_o=12'h000.
- Last tile: hpos=639, vpos=479 → buf_addr_o=599; char taken from buf_data_i[27:21]; tile_addr_o row=4'hF.
- Blanking/sync delay: video_on_i=0 with hpos=700 → buf_addr_o=0 and rgb_o=0 three cycles later. A 96-cycle hsync_i low pulse reproduces on hsync_o delayed by exactly 3 cycles, same width.
- Cursor blink (BLINK_FRAMES=2), cursor_en_i=1, cursor_pos_i=165, pixel hpos=40/vpos=35 with tile_data_i=8'h80:
  - After 2 vsync pulses → rgb_o=12'h000 (inverted).
  - After 4 pulses → 12'hFFF.
  - With cursor_en_i=0 → always 12'hFFF.
- Reset mid-stream: assert rstn_i for 1 cycle during the active area → outputs zero next cycle; valid pixels resume 3 cycles after release; blink phase is 0.
